// File: rtl/eth_mmio_arbiter.sv
// eth_mmio_arbiter: round-robin share of the ethernet MMIO port with bus lock.
// Define ETH_MMIO_ARB_LOCK_TIMEOUT_EN to force-release locks after max_lock_p cycles.
module eth_mmio_arbiter #(
  parameter int num_req_p     = 2,
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 14,
  parameter int max_lock_p    = 64,
  parameter int size_width_lp =
    $clog2(((data_width_p/8) > 1 ? $clog2(data_width_p/8) : 1) + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p-1:0]              req_we_i,
  input  logic [num_req_p-1:0]              req_lock_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*size_width_lp-1:0] req_size_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic [addr_width_p-1:0]           addr_o,
  output logic                              write_en_o,
  output logic                              read_en_o,
  output logic [size_width_lp-1:0]          op_size_o,
  output logic [data_width_p-1:0]           write_data_o,
  input  logic [data_width_p-1:0]           read_data_i,
  input  logic                              read_data_v_i,
  output logic                              lock_timeout_o
);

  localparam int id_w = $clog2(num_req_p);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]      state_r, state_n;
  logic [id_w-1:0] rr_r, owner_r, rd_owner_r, gnt;
  logic            gnt_v, rd_v_r, rd_issue, release_w, timeout;

  // Later candidates overwrite earlier ones, so the nearest after rr wins.
  always_comb begin : arb
    logic [id_w-1:0] idx;
    idx   = rr_r;
    gnt   = rr_r;
    gnt_v = 1'b0;
    unique case (state_r)
      LOCKED: begin
        gnt   = owner_r;
        gnt_v = req_v_i[owner_r];
      end
      IDLE: begin
        for (int i = num_req_p; i >= 1; i--) begin
          idx = id_w'((int'(rr_r) + i) % num_req_p);
          if (req_v_i[idx]) begin
            gnt   = idx;
            gnt_v = 1'b1;
          end
        end
      end
    endcase
    if (reset_i) gnt_v = 1'b0;
  end

  assign release_w = gnt_v & ~req_lock_i[gnt];
  assign rd_issue  = gnt_v & ~req_we_i[gnt];

`ifdef ETH_MMIO_ARB_LOCK_TIMEOUT_EN
  localparam int cnt_w = (max_lock_p > 1) ? $clog2(max_lock_p) : 1;
  logic [cnt_w-1:0] cnt_r;

  assign timeout = ~reset_i & (state_r == LOCKED) & ~release_w
                 & (cnt_r == cnt_w'(max_lock_p - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || state_r != LOCKED) cnt_r <= '0;
    else                              cnt_r <= cnt_r + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign lock_timeout_o = timeout;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:   if (gnt_v && req_lock_i[gnt]) state_n = LOCKED;
      LOCKED: if (release_w || timeout)     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      rr_r       <= id_w'(num_req_p - 1);
      owner_r    <= '0;
      rd_owner_r <= '0;
      rd_v_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      if (gnt_v && state_r == IDLE) begin
        rr_r    <= gnt;
        owner_r <= gnt;
      end
      if (rd_issue) begin
        rd_v_r     <= 1'b1;
        rd_owner_r <= gnt;
      end else if (read_data_v_i) begin
        rd_v_r <= 1'b0;
      end
    end
  end

  always_comb begin
    req_yumi_o = '0;
    if (gnt_v) req_yumi_o[gnt] = 1'b1;
    resp_v_o = '0;
    if (!reset_i && read_data_v_i && rd_v_r) resp_v_o[rd_owner_r] = 1'b1;
  end

  assign addr_o       = req_addr_i[gnt*addr_width_p +: addr_width_p];
  assign op_size_o    = req_size_i[gnt*size_width_lp +: size_width_lp];
  assign write_data_o = req_data_i[gnt*data_width_p +: data_width_p];
  assign write_en_o   = gnt_v & req_we_i[gnt];
  assign read_en_o    = rd_issue;
  assign resp_data_o  = read_data_i;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && read_data_v_i && !rd_v_r)
      $error("eth_mmio_arbiter: read data with no outstanding read");
  end
`endif

endmodule

// File: doc/eth_mmio_arbiter.md
Name: eth_mmio_arbiter

Overview:
- Shares the single MMIO port of the ethernet controller between num_req_p requesters, for example a core and a TX/RX DMA engine.
- Uses round-robin arbitration, with an optional bus lock so one requester can run an uninterrupted multi-access sequence (fill TX buffer, write size, send).
- Routes each sync-read response back to the requester that issued the read.
- Sits directly in front of the controller's addr/write_en/read_en/op_size/write_data/read_data port.

Parameters:
- num_req_p, 2, number of requesters (>=2).
- data_width_p, 32, MMIO data width.
- addr_width_p, 14, MMIO address width.
- max_lock_p, 64, maximum cycles a lock may be held (used only with the optional feature).
- size_width_lp, derived, `BSG_WIDTH(`BSG_SAFE_CLOG2(data_width_p/8)).

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  synchronous active-high reset
- req_v_i  in  num_req_p  per-requester request valid
- req_we_i  in  num_req_p  1=write, 0=read
- req_lock_i  in  num_req_p  hold the bus after this access
- req_addr_i  in  num_req_p*addr_width_p  packed addresses
- req_size_i  in  num_req_p*size_width_lp  packed op sizes
- req_data_i  in  num_req_p*data_width_p  packed write data
- req_yumi_o  out  num_req_p  one-hot accept, same cycle as issue
- resp_data_o  out  data_width_p  read data (shared)
- resp_v_o  out  num_req_p  one-hot read-response valid
- addr_o  out  addr_width_p  to controller addr_i
- write_en_o  out  1  to controller write_en_i
- read_en_o  out  1  to controller read_en_i
- op_size_o  out  size_width_lp  to controller op_size_i
- write_data_o  out  data_width_p  to controller write_data_i
- read_data_i  in  data_width_p  from controller read_data_o
- read_data_v_i  in  1  from controller read_data_v_o
- lock_timeout_o  out  1  one-cycle pulse on forced lock release

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - state=IDLE; rr pointer=num_req_p-1, so requester 0 has highest priority first.
  - req_yumi_o=0, resp_v_o=0, write_en_o=0, read_en_o=0, lock_timeout_o=0.
  - read owner register cleared and invalid; lock counter=0.
- Issue timing:
  - Issue is combinational from the selected requester: zero-cycle latency from grant to write_en_o/read_en_o.
  - When idle, addr_o/op_size_o/write_data_o may carry don't-care values.
- States:
  - IDLE: grant the first requester with req_v_i=1, searching from rr+1 modulo num_req_p.
    - Assert req_yumi_o[g] and drive its fields downstream; write_en_o=req_we_i[g], read_en_o=~req_we_i[g].
    - Update rr to g.
    - If req_lock_i[g]=1, go to LOCKED with owner=g.
  - LOCKED: only the owner is eligible.
    - Owner req_v_i=0: no issue, stay LOCKED; other requesters stall.
    - Owner access granted with req_lock_i=0: that access is the last one; go to IDLE next cycle.
    - Owner access granted with req_lock_i=1: stay LOCKED.
- Read return:
  - On a read issue, register owner id and a valid bit. The controller returns data exactly 1 cycle later.
  - On read_data_v_i=1 with a valid owner: resp_v_o[owner]=1 and resp_data_o=read_data_i combinationally, then clear the valid bit unless a new read issues in the same cycle.
  - Back-to-back reads from different requesters every cycle are supported; each response goes to its own issuer.
  - read_data_v_i=1 with no valid owner: response dropped; a simulation-only $error fires.
- Fairness: a requester holding req_v_i waits at most num_req_p-1 grants when no locks are held.
- Reset mid-lock or mid-read: returns to IDLE; any pending response is discarded (resp_v_o=0).

Optional Feature:
- Macro: ETH_MMIO_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle in LOCKED and clears on entering LOCKED.
  - When the counter reaches max_lock_p-1 in LOCKED without a release, the next cycle forces IDLE and pulses lock_timeout_o=1 for 1 cycle. rr stays at the owner, so the owner has lowest priority next.
  - An owner access in that final cycle is still granted normally.
- Undefined: no counter; lock_timeout_o tied 0; a lock is held indefinitely.

Test Plan:
- Round-robin: req0 and req1 both hold valid writes for 4 cycles after reset -> grant order 0,1,0,1; write_en_o=1 every cycle with the matching addr_o.
- Read routing: req1 reads 0x0010 at cycle t, req0 reads 0x0014 at t+1; controller returns 0xA, then 0xB -> resp_v_o=2'b10 with 0xA at t+1, resp_v_o=2'b01 with 0xB at t+2.
- Lock: req0 issues 3 writes with lock=1,1,0 and idles one cycle in between while req1 is valid throughout -> req1 gets no yumi until the cycle after req0's lock=0 write.
- Reset mid-lock: req0 is locked with a read outstanding; assert reset_i for 1 cycle -> IDLE, resp_v_o=0, then requester 0 wins the next arbitration.
- Timeout (macro defined, max_lock_p=4): req0 locks and then idles -> lock_timeout_o pulses 4 cycles after the locking grant and req1 is granted the following cycle. With the macro undefined, req1 is never granted.
